time_set_ctrl: RTL and testbench

Key-driven run/stop and time-edit controller that drives the update side of the stopwatch time counter. It reads the counter's current min/sec/deci_sec and issues the run/stop `state` level. It lets the user select a field and step it up or down, then pushes the edited value back through a packed 24-bit `update` word with a one-cycle `update_trigger`. It sits between the debounced key module and the time counter; its `edit_field`/`blink` outputs feed the display driver.

---
 rtl/time_set_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/stop and time-edit controller for the stopwatch.
// Drives the counter's update port and the display's field/blink hints.
module time_set_ctrl #(
    parameter logic [7:0] min_start      = 8'd0,
    parameter logic [7:0] min_MAX        = 8'd59,
    parameter logic [7:0] sec_start      = 8'd0,
    parameter logic [7:0] sec_MAX        = 8'd59,
    parameter logic [7:0] deci_sec_start = 8'd0,
    parameter logic [7:0] deci_sec_MAX   = 8'd9,
    parameter int unsigned blink_MAX     = 24_999_999
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        key_start,
    input  logic        key_sel,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic        key_clr,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_sec,
    input  logic [7:0]  cur_deci_sec,
    output logic        state,
    output logic [23:0] update,
    output logic        update_trigger,
    output logic [1:0]  edit_field,
    output logic        blink
);

    localparam int unsigned BW = (blink_MAX < 1) ? 1 : $clog2(blink_MAX + 1);
    localparam logic [BW-1:0] BLINK_END = BW'(blink_MAX);

    typedef enum logic [2:0] {
        RUN,
        STOP,
        EDIT_MIN,
        EDIT_SEC,
        EDIT_DSEC
    } mode_t;

    mode_t st_q, st_d;

    logic [7:0] sh_min, sh_sec, sh_dsec;
    logic [7:0] min_d, sec_d, dsec_d;
    logic       trig_d;
    logic       brst;
    logic       run_q;
    logic [1:0] edit_q;
    logic       trig_q;
    logic [BW-1:0] bcnt;
    logic       blink_q;

    // Step up with wrap back to the low value once the top is reached.
    function automatic logic [7:0] step_up(
        input logic [7:0] f,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (f >= hi) ? lo : f + 8'd1;
    endfunction

    // Step down with wrap to the top; out-of-range values snap to the top.
    function automatic logic [7:0] step_dn(
        input logic [7:0] f,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        if (f <= lo)
            return hi;
        else if (f > hi)
            return hi;
        else
            return f - 8'd1;
    endfunction

    // Display field code for a given FSM state.
    function automatic logic [1:0] field_of(input mode_t s);
        logic [1:0] r;
        r = 2'd0;
        case (s)
            EDIT_MIN:  r = 2'd1;
            EDIT_SEC:  r = 2'd2;
            EDIT_DSEC: r = 2'd3;
            default:   r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_edit(input mode_t s);
        return (s == EDIT_MIN) || (s == EDIT_SEC) || (s == EDIT_DSEC);
    endfunction

    // FSM state register.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst)
            st_q <= STOP;
        else
            st_q <= st_d;
    end

    // Next state, next shadow values and strobe; one key action per cycle.
    always_comb begin
        st_d   = st_q;
        min_d  = sh_min;
        sec_d  = sh_sec;
        dsec_d = sh_dsec;
        trig_d = 1'b0;
        brst   = 1'b0;
        unique case (st_q)
            RUN: begin
                if (key_start)
                    st_d = STOP;
            end
            STOP: begin
                if (key_start) begin
                    st_d = RUN;
                end else if (key_clr) begin
                    min_d  = min_start;
                    sec_d  = sec_start;
                    dsec_d = deci_sec_start;
                    trig_d = 1'b1;
                end else if (key_sel) begin
                    st_d   = EDIT_MIN;
                    min_d  = cur_min;
                    sec_d  = cur_sec;
                    dsec_d = cur_deci_sec;
                    brst   = 1'b1;
                end
            end
            EDIT_MIN, EDIT_SEC, EDIT_DSEC: begin
                if (key_start) begin
                    st_d = RUN;
                end else if (key_clr) begin
                    min_d  = min_start;
                    sec_d  = sec_start;
                    dsec_d = deci_sec_start;
                    trig_d = 1'b1;
                    brst   = 1'b1;
                end else if (key_sel) begin
                    brst = 1'b1;
                    case (st_q)
                        EDIT_MIN: st_d = EDIT_SEC;
                        EDIT_SEC: st_d = EDIT_DSEC;
                        default:  st_d = STOP;
                    endcase
                end else if (key_inc || key_dec) begin
                    trig_d = 1'b1;
                    brst   = 1'b1;
                    case (st_q)
                        EDIT_MIN:
                            min_d = key_inc
                                ? step_up(sh_min, min_start, min_MAX)
                                : step_dn(sh_min, min_start, min_MAX);
                        EDIT_SEC:
                            sec_d = key_inc
                                ? step_up(sh_sec, sec_start, sec_MAX)
                                : step_dn(sh_sec, sec_start, sec_MAX);
                        default:
                            dsec_d = key_inc
                                ? step_up(sh_dsec, deci_sec_start, deci_sec_MAX)
                                : step_dn(sh_dsec, deci_sec_start, deci_sec_MAX);
                    endcase
                end
            end
            default: begin
                st_d = STOP;
            end
        endcase
    end

    // Registered shadow time, strobe and state-derived outputs.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            sh_min  <= min_start;
            sh_sec  <= sec_start;
            sh_dsec <= deci_sec_start;
            trig_q  <= 1'b0;
            run_q   <= 1'b0;
            edit_q  <= 2'd0;
        end else begin
            sh_min  <= min_d;
            sh_sec  <= sec_d;
            sh_dsec <= dsec_d;
            trig_q  <= trig_d;
            run_q   <= (st_d == RUN);
            edit_q  <= field_of(st_d);
        end
    end

    // Blink half-period counter; restarts on field entry and every edit.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            bcnt    <= '0;
            blink_q <= 1'b0;
        end else if (!is_edit(st_d) || brst) begin
            bcnt    <= '0;
            blink_q <= 1'b0;
        end else if (bcnt == BLINK_END) begin
            bcnt    <= '0;
            blink_q <= ~blink_q;
        end else begin
            bcnt    <= bcnt + BW'(1);
        end
    end

    assign state          = run_q;
    assign update         = {sh_min, sh_sec, sh_dsec};
    assign update_trigger = trig_q;
    assign edit_field     = edit_q;
    assign blink          = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random checks of time_set_ctrl
// against a field-array reference model.
module tb_time_set_ctrl;

    localparam int BM = 3;
    localparam logic [4:0] KS = 5'b10000;
    localparam logic [4:0] KC = 5'b01000;
    localparam logic [4:0] KSEL = 5'b00100;
    localparam logic [4:0] KI = 5'b00010;
    localparam logic [4:0] KD = 5'b00001;

    logic sclk = 1'b0;
    logic nrst = 1'b0;
    logic key_start = 1'b0, key_sel = 1'b0, key_inc = 1'b0;
    logic key_dec = 1'b0, key_clr = 1'b0;
    logic [7:0] cur_min = 8'd0, cur_sec = 8'd0, cur_deci_sec = 8'd0;
    logic state;
    logic [23:0] update;
    logic update_trigger;
    logic [1:0] edit_field;
    logic blink;

    time_set_ctrl #(.blink_MAX(BM)) dut (
        .sclk(sclk),
        .nrst(nrst),
        .key_start(key_start),
        .key_sel(key_sel),
        .key_inc(key_inc),
        .key_dec(key_dec),
        .key_clr(key_clr),
        .cur_min(cur_min),
        .cur_sec(cur_sec),
        .cur_deci_sec(cur_deci_sec),
        .state(state),
        .update(update),
        .update_trigger(update_trigger),
        .edit_field(edit_field),
        .blink(blink)
    );

    always #5 sclk = ~sclk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0 = running, 1 = stopped, 2..4 = editing
    // field (mode-2); fields kept as plain integers.
    int m_mode = 1;
    int m_f[3] = '{0, 0, 0};
    bit m_trig = 0;
    int m_bc = 0;
    bit m_bl = 0;
    int st_v[3] = '{0, 0, 0};
    int mx_v[3] = '{59, 59, 9};

    always @(posedge sclk or negedge nrst) begin : model
        int mode;
        int f[3];
        int bc;
        bit bl, tr, rs;
        if (!nrst) begin
            m_mode <= 1;
            m_f <= st_v;
            m_trig <= 0;
            m_bc <= 0;
            m_bl <= 0;
        end else begin
            mode = m_mode;
            f = m_f;
            bc = m_bc;
            bl = m_bl;
            tr = 0;
            rs = 0;
            if (mode == 0) begin
                if (key_start) mode = 1;
            end else if (key_start) begin
                mode = 0;
            end else if (key_clr) begin
                f = st_v;
                tr = 1;
                rs = 1;
            end else if (key_sel) begin
                if (mode == 1) begin
                    f[0] = cur_min;
                    f[1] = cur_sec;
                    f[2] = cur_deci_sec;
                    mode = 2;
                end else begin
                    mode = (mode == 4) ? 1 : mode + 1;
                end
                rs = 1;
            end else if (mode >= 2 && (key_inc || key_dec)) begin
                int i;
                i = mode - 2;
                if (key_inc)
                    f[i] = (f[i] >= mx_v[i]) ? st_v[i] : f[i] + 1;
                else if (f[i] <= st_v[i] || f[i] > mx_v[i])
                    f[i] = mx_v[i];
                else
                    f[i] = f[i] - 1;
                tr = 1;
                rs = 1;
            end
            if (mode < 2 || rs) begin
                bc = 0;
                bl = 0;
            end else if (bc == BM) begin
                bc = 0;
                bl = !bl;
            end else begin
                bc = bc + 1;
            end
            m_mode <= mode;
            m_f <= f;
            m_trig <= tr;
            m_bc <= bc;
            m_bl <= bl;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge sclk) begin
        if (chk_en && nrst) begin
            logic [23:0] ex_up;
            ex_up = {m_f[0][7:0], m_f[1][7:0], m_f[2][7:0]};
            chk("m_state", 32'(state), 32'(m_mode == 0));
            chk("m_update", 32'(update), 32'(ex_up));
            chk("m_trig", 32'(update_trigger), 32'(m_trig));
            chk("m_field", 32'(edit_field),
                (m_mode >= 2) ? 32'(m_mode - 1) : 32'd0);
            chk("m_blink", 32'(blink), 32'(m_bl));
            if (update_trigger && state) chk("trig_in_run", 32'd1, 32'd0);
        end
    end

    task automatic step(input logic [4:0] k);
        {key_start, key_clr, key_sel, key_inc, key_dec} = k;
        @(negedge sclk);
        {key_start, key_clr, key_sel, key_inc, key_dec} = 5'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic set_cur(input int m, input int s, input int d);
        cur_min = 8'(m);
        cur_sec = 8'(s);
        cur_deci_sec = 8'(d);
    endtask

    initial begin
        idle(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_update", 32'(update), 32'h000000);
        chk("rst_trig", 32'(update_trigger), 32'd0);
        chk("rst_field", 32'(edit_field), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        nrst = 1'b1;
        chk_en = 1;
        idle(1);

        step(KS);
        chk("run_state", 32'(state), 32'd1);
        chk("run_trig", 32'(update_trigger), 32'd0);
        step(KS);
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_trig", 32'(update_trigger), 32'd0);

        set_cur(2, 30, 5);
        step(KSEL);
        chk("sel_field", 32'(edit_field), 32'd1);
        chk("sel_capture", 32'(update), 32'h021E05);
        chk("sel_trig", 32'(update_trigger), 32'd0);
        step(KI);
        chk("inc_min", 32'(update), 32'h031E05);
        chk("inc_trig", 32'(update_trigger), 32'd1);
        idle(1);
        chk("inc_trig_off", 32'(update_trigger), 32'd0);
        chk("inc_hold", 32'(update), 32'h031E05);

        step(KSEL);
        step(KSEL);
        step(KSEL);
        chk("back_stop", 32'(edit_field), 32'd0);
        set_cur(2, 59, 12);
        step(KSEL);
        step(KSEL);
        chk("sec_field", 32'(edit_field), 32'd2);
        step(KI);
        chk("sec_wrap_up", 32'(update), 32'h02000C);
        step(KD);
        chk("sec_wrap_dn", 32'(update), 32'h023B0C);
        chk("sec_trig1", 32'(update_trigger), 32'd1);
        step(KD);
        chk("sec_dec", 32'(update), 32'h023A0C);
        chk("sec_trig2", 32'(update_trigger), 32'd1);
        step(KSEL);
        step(KD);
        chk("dsec_snap", 32'(update), 32'h023A09);
        step(KI);
        chk("dsec_wrap", 32'(update), 32'h023A00);

        step(KSEL);
        step(KSEL);
        chk("recap", 32'(update), 32'h023B0C);
        step(KC | KI);
        chk("clr_update", 32'(update), 32'h000000);
        chk("clr_trig", 32'(update_trigger), 32'd1);
        chk("clr_field", 32'(edit_field), 32'd1);
        idle(3);
        chk("blink_k3", 32'(blink), 32'd0);
        chk("clr_single", 32'(update_trigger), 32'd0);
        idle(1);
        chk("blink_k4", 32'(blink), 32'd1);
        idle(3);
        chk("blink_k7", 32'(blink), 32'd1);
        idle(1);
        chk("blink_k8", 32'(blink), 32'd0);
        step(KSEL);
        step(KSEL);
        step(KSEL);
        chk("exit_field", 32'(edit_field), 32'd0);
        chk("exit_blink", 32'(blink), 32'd0);
        chk("exit_state", 32'(state), 32'd0);

        set_cur(7, 8, 9);
        step(KSEL);
        step(KI);
        #2 nrst = 1'b0;
        #1;
        chk("arst_field", 32'(edit_field), 32'd0);
        chk("arst_update", 32'(update), 32'h000000);
        chk("arst_trig", 32'(update_trigger), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        @(negedge sclk);
        nrst = 1'b1;
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            key_start = ($urandom_range(0, 11) == 0);
            key_clr = ($urandom_range(0, 15) == 0);
            key_sel = ($urandom_range(0, 9) == 0);
            key_inc = ($urandom_range(0, 7) == 0);
            key_dec = ($urandom_range(0, 7) == 0);
            set_cur($urandom_range(0, 70), $urandom_range(0, 70),
                    $urandom_range(0, 14));
            @(negedge sclk);
        end
        {key_start, key_clr, key_sel, key_inc, key_dec} = 5'b0;
        idle(2);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
